// File: rtl/ext_alu_sequencer.sv
// rtl/ext_alu_sequencer.sv - request/response sequencer for an external strobe/ack float ALU
// Pushes operand A, then operand B, waits for the result, acknowledges it and returns it.
module ext_alu_sequencer #(
    parameter int DATA_W = 32,
    parameter int OP_W   = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [OP_W-1:0]   req_op,
    input  logic [DATA_W-1:0] req_a,
    input  logic [DATA_W-1:0] req_b,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_data,
    output logic              rsp_err,
    output logic [DATA_W-1:0] alu_op1,
    output logic [DATA_W-1:0] alu_op2,
    output logic [OP_W-1:0]   alu_op,
    output logic [2:0]        alu_csr_in,
    input  logic [2:0]        alu_csr_out,
    input  logic [DATA_W-1:0] alu_result,
    output logic              busy
);

    localparam logic [2:0] IDLE   = 3'd0;
    localparam logic [2:0] SEND_A = 3'd1;
    localparam logic [2:0] SEND_B = 3'd2;
    localparam logic [2:0] WAIT_Z = 3'd3;
    localparam logic [2:0] ACK_Z  = 3'd4;
    localparam logic [2:0] RESP   = 3'd5;

    localparam logic [OP_W-1:0] OP_DIV = OP_W'(1);
    localparam logic [OP_W-1:0] OP_MUL = OP_W'(2);

    // alu_csr_in bit positions: {b_stb, a_stb, z_ack}
    localparam logic [2:0] CSR_Z_ACK = 3'b001;
    localparam logic [2:0] CSR_A_STB = 3'b010;
    localparam logic [2:0] CSR_B_STB = 3'b100;

    logic [2:0] state;
    logic       a_ack;
    logic       b_ack;
    logic       z_stb;

    assign a_ack = alu_csr_out[0];
    assign b_ack = alu_csr_out[1];
    assign z_stb = alu_csr_out[2];

    // Every output is a register; each state transition sets the outputs of the state it enters.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            req_ready  <= 1'b0;
            busy       <= 1'b0;
            rsp_valid  <= 1'b0;
            rsp_err    <= 1'b0;
            rsp_data   <= '0;
            alu_op     <= '0;
            alu_op1    <= '0;
            alu_op2    <= '0;
            alu_csr_in <= '0;
        end else begin
            case (state)
                IDLE: begin
                    alu_op     <= '0;
                    alu_csr_in <= '0;
                    if (req_valid && req_ready) begin
                        req_ready <= 1'b0;
                        busy      <= 1'b1;
                        if (req_op == OP_DIV || req_op == OP_MUL) begin
                            state      <= SEND_A;
                            alu_op     <= req_op;
                            alu_op1    <= req_a;
                            alu_op2    <= req_b;
                            alu_csr_in <= CSR_A_STB;
                        end else begin
                            // Illegal opcode never reaches the ALU.
                            state     <= RESP;
                            rsp_valid <= 1'b1;
                            rsp_err   <= 1'b1;
                            rsp_data  <= '0;
                        end
                    end else begin
                        req_ready <= 1'b1;
                    end
                end
                SEND_A: begin
                    if (a_ack) begin
                        state      <= SEND_B;
                        alu_csr_in <= CSR_B_STB;
                    end
                end
                SEND_B: begin
                    if (b_ack) begin
                        state      <= WAIT_Z;
                        alu_csr_in <= '0;
                    end
                end
                WAIT_Z: begin
                    if (z_stb) begin
                        state      <= ACK_Z;
                        rsp_data   <= alu_result;
                        alu_csr_in <= CSR_Z_ACK;
                    end
                end
                ACK_Z: begin
                    state      <= RESP;
                    alu_csr_in <= '0;
                    alu_op     <= '0;
                    rsp_valid  <= 1'b1;
                    rsp_err    <= 1'b0;
                end
                RESP: begin
                    if (rsp_ready) begin
                        state     <= IDLE;
                        rsp_valid <= 1'b0;
                        req_ready <= 1'b1;
                        busy      <= 1'b0;
                    end
                end
                default: begin
                    state      <= IDLE;
                    req_ready  <= 1'b1;
                    busy       <= 1'b0;
                    rsp_valid  <= 1'b0;
                    alu_op     <= '0;
                    alu_csr_in <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ext_alu_sequencer.sv
// tb/tb_ext_alu_sequencer.sv - directed self-checking bench for ext_alu_sequencer
// Includes a behavioural strobe/ack ALU with programmable a_ack and z_stb delays.
module tb_ext_alu_sequencer;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic [1:0]  req_op;
    logic [31:0] req_a;
    logic [31:0] req_b;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_data;
    logic        rsp_err;
    logic [31:0] alu_op1;
    logic [31:0] alu_op2;
    logic [1:0]  alu_op;
    logic [2:0]  alu_csr_in;
    logic [2:0]  alu_csr_out;
    logic [31:0] alu_result;
    logic        busy;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    ext_alu_sequencer #(.DATA_W(32), .OP_W(2)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_op(req_op), .req_a(req_a), .req_b(req_b),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_data(rsp_data), .rsp_err(rsp_err),
        .alu_op1(alu_op1), .alu_op2(alu_op2), .alu_op(alu_op),
        .alu_csr_in(alu_csr_in), .alu_csr_out(alu_csr_out),
        .alu_result(alu_result), .busy(busy)
    );

    // Behavioural external ALU
    int          a_dly = 0;
    int          z_dly = 0;
    logic        spur_en = 1'b0;
    int          a_cnt;
    int          z_cnt;
    logic        z_pend;
    logic [31:0] ma, mb;
    logic        a_ack_m, b_ack_m, z_stb_m, spur;

    function automatic logic [31:0] model_res(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
        if (op == 2'd2 && a == 32'h40C00000 && b == 32'h40E00000) return 32'h42280000;
        if (op == 2'd2 && a == 32'h40000000 && b == 32'h40400000) return 32'h40C00000;
        if (op == 2'd1 && a == 32'h42280000 && b == 32'h40E00000) return 32'h40C00000;
        return 32'hDEADBEEF;
    endfunction

    assign a_ack_m     = alu_csr_in[1] && (a_cnt >= a_dly);
    assign b_ack_m     = alu_csr_in[2];
    assign z_stb_m     = z_pend && (z_cnt >= z_dly);
    assign spur        = spur_en && alu_csr_in[1];
    assign alu_csr_out = {z_stb_m | spur, b_ack_m | spur, a_ack_m};
    assign alu_result  = model_res(alu_op, ma, mb);

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            a_cnt  <= 0;
            z_cnt  <= 0;
            z_pend <= 1'b0;
            ma     <= '0;
            mb     <= '0;
        end else begin
            if (alu_csr_in[1] && !a_ack_m) a_cnt <= a_cnt + 1;
            else a_cnt <= 0;
            if (alu_csr_in[1] && a_ack_m) ma <= alu_op1;
            if (alu_csr_in[2] && b_ack_m) begin
                mb     <= alu_op2;
                z_pend <= 1'b1;
                z_cnt  <= 0;
            end else if (alu_csr_in[0]) begin
                z_pend <= 1'b0;
            end else if (z_pend && !z_stb_m) begin
                z_cnt <= z_cnt + 1;
            end
        end
    end

    always @(negedge clk) begin
        if (!rst) begin
            checks++;
            if ($countones(alu_csr_in) > 1) begin
                errors++;
                $display("FAIL onehot_csr: alu_csr_in=%b, required at most one bit set", alu_csr_in);
            end
        end
    end

    task automatic run_req(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                           input logic [31:0] exp_d, input logic exp_e, input int exp_lat,
                           input int hold, input int exp_na, input string nm);
        int   cyc, lat, na, nb, nz, fa, fb, fz;
        logic unstable, hold_bad;
        cyc = 0;
        while (!req_ready && cyc < 100) begin
            @(negedge clk);
            cyc++;
        end
        checks++;
        if (req_ready !== 1'b1) begin
            errors++;
            $display("FAIL %s_ready: req_ready=%b, required 1", nm, req_ready);
        end
        req_valid = 1'b1; req_op = op; req_a = a; req_b = b;
        @(negedge clk);
        lat = 1; na = 0; nb = 0; nz = 0; fa = -1; fb = -1; fz = -1; unstable = 1'b0;
        while (lat < 200) begin
            if (alu_csr_in[1]) begin na++; if (fa < 0) fa = lat; end
            if (alu_csr_in[2]) begin nb++; if (fb < 0) fb = lat; end
            if (alu_csr_in[0]) begin nz++; if (fz < 0) fz = lat; end
            if (!rsp_valid && (alu_op !== op || alu_op1 !== a || alu_op2 !== b || req_ready !== 1'b0))
                unstable = 1'b1;
            if (rsp_valid) break;
            // junk on the request port while busy must be ignored
            req_valid = 1'b1; req_op = 2'($urandom); req_a = $urandom; req_b = $urandom;
            @(negedge clk);
            lat++;
        end
        req_valid = 1'b0;
        checks++;
        if (lat !== exp_lat) begin
            errors++;
            $display("FAIL %s_latency: got %0d cycles, required %0d", nm, lat, exp_lat);
        end
        checks++;
        if (rsp_valid !== 1'b1 || rsp_data !== exp_d || rsp_err !== exp_e) begin
            errors++;
            $display("FAIL %s_response: valid=%b data=%h err=%b, required 1 %h %b", nm, rsp_valid, rsp_data, rsp_err, exp_d, exp_e);
        end
        checks++;
        if (exp_e) begin
            if (na + nb + nz != 0 || alu_op !== 2'd0) begin
                errors++;
                $display("FAIL %s_no_strobes: a=%0d b=%0d z=%0d alu_op=%0d, required all 0", nm, na, nb, nz, alu_op);
            end
        end else if (na != exp_na || nb != 1 || nz != 1 || !(fa < fb && fb < fz)) begin
            errors++;
            $display("FAIL %s_strobes: a=%0d@%0d b=%0d@%0d z=%0d@%0d, required a=%0d b=1 z=1 in order",
                     nm, na, fa, nb, fb, nz, fz, exp_na);
        end
        if (!exp_e) begin
            checks++;
            if (unstable) begin
                errors++;
                $display("FAIL %s_operand_hold: alu_op/op1/op2 changed in flight, required %0d %h %h", nm, op, a, b);
            end
        end
        hold_bad = 1'b0;
        for (int i = 0; i < hold; i++) begin
            rsp_ready = 1'b0;
            @(negedge clk);
            if (rsp_valid !== 1'b1 || rsp_data !== exp_d || rsp_err !== exp_e || req_ready !== 1'b0)
                hold_bad = 1'b1;
        end
        if (hold > 0) begin
            checks++;
            if (hold_bad) begin
                errors++;
                $display("FAIL %s_resp_hold: response changed while rsp_ready=0, last valid=%b data=%h err=%b ready=%b",
                         nm, rsp_valid, rsp_data, rsp_err, req_ready);
            end
        end
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
        checks++;
        if (rsp_valid !== 1'b0 || req_ready !== 1'b1 || busy !== 1'b0) begin
            errors++;
            $display("FAIL %s_turnaround: rsp_valid=%b req_ready=%b busy=%b, required 0 1 0", nm, rsp_valid, req_ready, busy);
        end
    endtask

    task automatic check_all_zero(input string nm);
        checks++;
        if (rsp_valid !== 1'b0 || rsp_err !== 1'b0 || rsp_data !== 32'd0 || alu_op1 !== 32'd0 ||
            alu_op2 !== 32'd0 || alu_op !== 2'd0 || alu_csr_in !== 3'd0 || busy !== 1'b0 || req_ready !== 1'b0) begin
            errors++;
            $display("FAIL %s: valid=%b err=%b data=%h op1=%h op2=%h op=%0d csr=%b busy=%b ready=%b, required all 0",
                     nm, rsp_valid, rsp_err, rsp_data, alu_op1, alu_op2, alu_op, alu_csr_in, busy, req_ready);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; req_valid = 1'b0; req_op = '0; req_a = '0; req_b = '0; rsp_ready = 1'b0;
        #1;
        check_all_zero("reset_async");
        @(negedge clk);
        @(negedge clk);
        check_all_zero("reset_held");
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if (req_ready !== 1'b1 || busy !== 1'b0 || alu_csr_in !== 3'd0 || alu_op !== 2'd0) begin
            errors++;
            $display("FAIL reset_release: req_ready=%b busy=%b csr=%b op=%0d, required 1 0 000 0", req_ready, busy, alu_csr_in, alu_op);
        end
    endtask

    task automatic test_mul();
        a_dly = 0; z_dly = 0;
        run_req(2'd2, 32'h40C00000, 32'h40E00000, 32'h42280000, 1'b0, 5, 0, 1, "mul");
    endtask

    task automatic test_div();
        run_req(2'd1, 32'h42280000, 32'h40E00000, 32'h40C00000, 1'b0, 5, 0, 1, "div");
    endtask

    task automatic test_illegal();
        run_req(2'd0, 32'h40C00000, 32'h40E00000, 32'h00000000, 1'b1, 1, 0, 0, "illegal_op0");
        run_req(2'd3, 32'h12345678, 32'h9ABCDEF0, 32'h00000000, 1'b1, 1, 0, 0, "illegal_op3");
    endtask

    task automatic test_resp_hold();
        run_req(2'd2, 32'h40000000, 32'h40400000, 32'h40C00000, 1'b0, 5, 10, 1, "hold");
        run_req(2'd3, 32'h0, 32'h0, 32'h0, 1'b1, 1, 10, 0, "hold_err");
    endtask

    task automatic test_spurious();
        a_dly = 3; z_dly = 0; spur_en = 1'b1;
        run_req(2'd1, 32'h42280000, 32'h40E00000, 32'h40C00000, 1'b0, 8, 0, 4, "spurious");
        spur_en = 1'b0;
    endtask

    task automatic test_back_to_back();
        a_dly = 3; z_dly = 20;
        run_req(2'd2, 32'h40C00000, 32'h40E00000, 32'h42280000, 1'b0, 28, 0, 4, "b2b_first");
        run_req(2'd1, 32'h42280000, 32'h40E00000, 32'h40C00000, 1'b0, 28, 0, 4, "b2b_second");
        a_dly = 0; z_dly = 0;
    endtask

    task automatic test_reset_wait_z();
        int cyc;
        a_dly = 0; z_dly = 20;
        @(negedge clk);
        req_valid = 1'b1; req_op = 2'd2; req_a = 32'h40C00000; req_b = 32'h40E00000;
        @(negedge clk);
        req_valid = 1'b0;
        cyc = 0;
        while (!z_pend && cyc < 20) begin
            @(negedge clk);
            cyc++;
        end
        @(negedge clk);
        @(negedge clk);
        checks++;
        if (busy !== 1'b1 || alu_csr_in !== 3'd0 || rsp_valid !== 1'b0 || z_pend !== 1'b1) begin
            errors++;
            $display("FAIL rst_waitz_entry: busy=%b csr=%b rsp_valid=%b pend=%b, required 1 000 0 1", busy, alu_csr_in, rsp_valid, z_pend);
        end
        #2 rst = 1'b1;
        #1;
        check_all_zero("rst_waitz_async");
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if (req_ready !== 1'b1 || busy !== 1'b0) begin
            errors++;
            $display("FAIL rst_waitz_release: req_ready=%b busy=%b, required 1 0", req_ready, busy);
        end
        z_dly = 0;
        run_req(2'd2, 32'h40C00000, 32'h40E00000, 32'h42280000, 1'b0, 5, 0, 1, "after_rst_mul");
    endtask

    initial begin
        test_reset();
        test_mul();
        test_div();
        test_illegal();
        test_resp_hold();
        test_spurious();
        test_back_to_back();
        test_reset_wait_z();
        repeat (2) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/ext_alu_sequencer.md
EXT_ALU_SEQUENCER -- requirements
Module: ext_alu_sequencer

Interface
REQ-001 The block SHALL take parameter DATA_W, default 32, meaning the operand/result width (equals ALUDATABITS).
REQ-002 The block SHALL take parameter OP_W, default 2, meaning the ALU opcode width (equals ALUOPBITS); opcode 1 = divide, opcode 2 = multiply, all other values illegal.
REQ-003 The block SHALL have port clk  input  1  the single clock; all state changes on its rising edge.
REQ-004 The block SHALL have port rst  input  1  reset, asynchronous and active-high.
REQ-005 The block SHALL have port req_valid  input  1  a request is present.
REQ-006 The block SHALL have port req_ready  output  1  the block accepts a request this cycle.
REQ-007 The block SHALL have ports req_op  input  OP_W, req_a  input  DATA_W and req_b  input  DATA_W, carrying the request opcode and the two operands.
REQ-008 The block SHALL have ports rsp_valid  output  1 and rsp_ready  input  1, forming the response handshake.
REQ-009 The block SHALL have ports rsp_data  output  DATA_W and rsp_err  output  1, carrying the result and an error flag for an illegal opcode.
REQ-010 The block SHALL have ports alu_op1  output  DATA_W, alu_op2  output  DATA_W and alu_op  output  OP_W, driving the external ALU operands and unit select.
REQ-011 The block SHALL have port alu_csr_in  output  3, driving the external ALU strobes as bit0 = z_ack, bit1 = a_stb, bit2 = b_stb.
REQ-012 The block SHALL have port alu_csr_out  input  3, receiving the external ALU status as bit0 = a_ack, bit1 = b_ack, bit2 = z_stb.
REQ-013 The block SHALL have port alu_result  input  DATA_W, receiving the external ALU result.
REQ-014 The block SHALL have port busy  output  1, high whenever state is not IDLE.

Function
REQ-015 The FSM SHALL have the states IDLE, SEND_A, SEND_B, WAIT_Z, ACK_Z and RESP; the state register and all outputs SHALL be registered.
REQ-016 In IDLE the block SHALL hold req_ready=1, alu_op=0 and alu_csr_in=0; req_ready SHALL be 0 in every other state.
REQ-017 On req_valid&&req_ready the block SHALL latch req_op, req_a and req_b.
- If the opcode is legal, the next state SHALL be SEND_A.
- If the opcode is illegal, the next state SHALL be RESP with rsp_err=1 and rsp_data=0, and no strobe SHALL ever be asserted for that request.
REQ-018 From SEND_A through ACK_Z, alu_op, alu_op1 and alu_op2 SHALL hold the latched values, stable without change.
REQ-019 In SEND_A the block SHALL drive a_stb=1; in a cycle with a_ack=1 it SHALL go to SEND_B, so that a_stb=0 and b_stb=1 in the next cycle.
REQ-020 In SEND_B the block SHALL drive b_stb=1; in a cycle with b_ack=1 it SHALL go to WAIT_Z with all strobes 0.
REQ-021 In WAIT_Z, in a cycle with z_stb=1, the block SHALL capture alu_result into rsp_data and go to ACK_Z.
REQ-022 In ACK_Z the block SHALL drive z_ack=1 for exactly one cycle, then go to RESP with rsp_err=0.
REQ-023 In RESP the block SHALL hold rsp_valid=1 with rsp_data and rsp_err stable.
- On rsp_ready=1 the next state SHALL be IDLE.
- The rsp_valid-to-req_ready turnaround SHALL be 1 cycle, giving back-to-back throughput of one request per IDLE visit.
REQ-024 The block SHALL never assert more than one bit of alu_csr_in in the same cycle.
REQ-025 Latency from accept to rsp_valid SHALL be 4 + (number of SEND_A/SEND_B stall cycles) + (number of WAIT_Z cycles), with a 1-cycle minimum per state.
REQ-026 The block SHALL ignore ack/stb inputs that arrive outside the state that consumes them; for example, z_stb in SEND_A has no effect.
REQ-027 Request inputs SHALL be ignored while req_ready=0, and in-flight latched values SHALL be unaffected by them.

Reset
REQ-028 When rst is asserted, asynchronously and in any state including mid-operation, the block SHALL return to IDLE.
REQ-029 During reset, rsp_valid, rsp_err, rsp_data, alu_op1, alu_op2, alu_op, alu_csr_in and busy SHALL be 0, and req_ready SHALL be 0 while rst is high.
REQ-030 On the first clock edge after rst deasserts, req_ready SHALL be 1.
REQ-031 The external units share rst, so no drain sequence SHALL be required after a reset.

Verification
REQ-032 The bench SHALL cover: op=2, a=0x40C00000 (6.0), b=0x40E00000 (7.0), with real units -> rsp_data=0x42280000, rsp_err=0, a_stb/b_stb/z_ack each seen exactly once, in that order.
REQ-033 The bench SHALL cover: op=1, a=0x42280000, b=0x40E00000 -> rsp_data=0x40C00000, rsp_err=0, and alu_op=1 held stable from SEND_A through ACK_Z.
REQ-034 The bench SHALL cover: op=0 and op=3 -> rsp_valid 1 cycle after accept with rsp_err=1 and rsp_data=0, and alu_csr_in stays 0 throughout.
REQ-035 The bench SHALL cover: rsp_ready held 0 for 10 cycles in RESP -> rsp_valid, rsp_data and rsp_err stable, req_ready=0, then IDLE one cycle after rsp_ready=1.
REQ-036 The bench SHALL cover: rst pulsed while in WAIT_Z -> all outputs 0 immediately, req_ready=1 after release, and a following 6.0*7.0 multiply returns 0x42280000.
REQ-037 The bench SHALL cover: an ALU model delaying a_ack by 3 cycles and z_stb by 20 cycles, with two back-to-back requests -> strobes held until acked, latency per REQ-025, and both responses correct and in order.
